// File: rtl/mult8x8_seq_ctrl.sv
// mult8x8_seq_ctrl: sequencer and accumulator for a nibble-serial 8x8 multiplier.
// Steps through the four nibble pairs (lo*lo, hi*lo, lo*hi, hi*hi). It drives the
// nibble-mux selects and the alignment shift, and accumulates the aligned 4x4
// partial products into a 16-bit registered product.
// Optional build macro MULT8X8_SIGNED_EN: the operands are two's complement. The
// block multiplies magnitudes and negates the sum on the S3 -> DONE edge.
module mult8x8_seq_ctrl #(
  parameter int DONE_HOLD = 0
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic        sel_a,
  output logic        sel_b,
  output logic [1:0]  shift,
  output logic        busy,
  output logic        done_flag,
  output logic [15:0] product8x8_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  op_a_reg, op_b_reg;
  logic [15:0] acc_reg;
  logic        done_reg;

  logic        accept;
  logic [7:0]  load_a, load_b;
  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_aligned;
  logic [15:0] sum;
  logic [15:0] final_sum;

  // A start is only honoured between operations; starts while busy are dropped.
  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

`ifdef MULT8X8_SIGNED_EN
  logic sign_reg;

  // The magnitude of -128 is 0x80, which still fits the 8-bit unsigned datapath.
  assign load_a    = dataa[7] ? (~dataa + 8'd1) : dataa;
  assign load_b    = datab[7] ? (~datab + 8'd1) : datab;
  assign final_sum = sign_reg ? (~sum + 16'd1) : sum;

  // Result sign is captured alongside the magnitudes at the accept edge.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      sign_reg <= 1'b0;
    end else if (accept) begin
      sign_reg <= dataa[7] ^ datab[7];
    end
  end
`else
  assign load_a    = dataa;
  assign load_b    = datab;
  assign final_sum = sum;
`endif

  // Nibble muxes and the 4x4 multiplier, steered by the Moore select lines.
  assign nib_a = sel_a ? op_a_reg[7:4] : op_a_reg[3:0];
  assign nib_b = sel_b ? op_b_reg[7:4] : op_b_reg[3:0];
  assign pp    = nib_a * nib_b;

  // Zero-extend the partial product to 16 bits and align it by 0/4/8 bits.
  always_comb begin
    pp_aligned = {8'd0, pp};
    case (shift)
      2'd1:    pp_aligned = {4'd0, pp, 4'd0};
      2'd2:    pp_aligned = {pp, 8'd0};
      default: pp_aligned = {8'd0, pp};
    endcase
  end

  assign sum = acc_reg + pp_aligned;

  // Next-state logic and the Moore select/shift/busy outputs for each step.
  always_comb begin
    state_next = state_reg;
    sel_a      = 1'b0;
    sel_b      = 1'b0;
    shift      = 2'd0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = S0;
      S0: begin
        busy = 1'b1;
        state_next = S1;
      end
      S1: begin
        sel_a = 1'b1; shift = 2'd1; busy = 1'b1;
        state_next = S2;
      end
      S2: begin
        sel_b = 1'b1; shift = 2'd1; busy = 1'b1;
        state_next = S3;
      end
      S3: begin
        sel_a = 1'b1; sel_b = 1'b1; shift = 2'd2; busy = 1'b1;
        state_next = DONE;
      end
      DONE: state_next = start ? S0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, operand latches, accumulator and done flag.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_reg <= IDLE;
      op_a_reg  <= 8'd0;
      op_b_reg  <= 8'd0;
      acc_reg   <= 16'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_a_reg <= load_a;
        op_b_reg <= load_b;
        acc_reg  <= 16'd0;
        done_reg <= 1'b0;
      end else begin
        case (state_reg)
          S0, S1, S2: acc_reg <= sum;
          S3: begin
            acc_reg  <= final_sum;
            done_reg <= 1'b1;
          end
          DONE: if (DONE_HOLD == 0) done_reg <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign done_flag      = done_reg;
  assign product8x8_out = acc_reg;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// tb_mult8x8_seq_ctrl: table-driven and scoreboard-checked bench for mult8x8_seq_ctrl.
// It runs two instances side by side: DONE_HOLD = 0 (u_dut0) and DONE_HOLD = 1 (u_dut1).
// Build with MULT8X8_SIGNED_EN defined to select the signed expectations.
module tb_mult8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_a = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  dataa = 8'd0;
  logic [7:0]  datab = 8'd0;

  logic        sel_a0, sel_b0, busy0, done0;
  logic [1:0]  shift0;
  logic [15:0] prod0;
  logic        sel_a1, sel_b1, busy1, done1;
  logic [1:0]  shift1;
  logic [15:0] prod1;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] exp;
    int          stamp;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;

  mult8x8_seq_ctrl #(.DONE_HOLD(0)) u_dut0 (
    .clk(clk), .reset_a(reset_a), .start(start), .dataa(dataa), .datab(datab),
    .sel_a(sel_a0), .sel_b(sel_b0), .shift(shift0), .busy(busy0),
    .done_flag(done0), .product8x8_out(prod0)
  );

  mult8x8_seq_ctrl #(.DONE_HOLD(1)) u_dut1 (
    .clk(clk), .reset_a(reset_a), .start(start), .dataa(dataa), .datab(datab),
    .sel_a(sel_a1), .sel_b(sel_b1), .shift(shift1), .busy(busy1),
    .done_flag(done1), .product8x8_out(prod1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input logic [15:0] exp);
    sb_t e;
    e.exp   = exp;
    e.stamp = edge_cnt;
    sb_q.push_back(e);
  endfunction

  // Scoreboard: each done pulse of the pulse-mode instance retires one expected result.
  always @(negedge clk) begin
    if (reset_a && done0) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: product %0d with empty scoreboard", prod0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        $display("[TB] result %0d (0x%04h), expected %0d, latency %0d edges",
                 prod0, prod0, e.exp, edge_cnt - e.stamp - 1);
        chk("product_dut0", prod0, e.exp);
        chk("product_dut1", prod1, e.exp);
        chk("done_dut1", done1, 1);
        chk("latency", edge_cnt - e.stamp, 5);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_prod0"}, prod0, 0);
    chk({tag, "_done0"}, done0, 0);
    chk({tag, "_busy0"}, busy0, 0);
    chk({tag, "_sel0"}, {sel_a0, sel_b0, shift0}, 0);
    chk({tag, "_prod1"}, prod1, 0);
    chk({tag, "_done1"}, done1, 0);
    chk({tag, "_busy1"}, busy1, 0);
  endtask

  // One complete operation: a one-cycle start, per-step select checks, and a return at DONE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    @(negedge clk);
    start = 1'b1; dataa = a; datab = b;
    push_exp(exp);
    @(negedge clk);
    start = 1'b0; dataa = ~a; datab = ~b;
    chk("s0_acc_cleared", prod0, 0);
    chk("s0_done0_low", done0, 0);
    chk("s0_done1_low", done1, 0);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("step%0d_sel_a", s), sel_a0, (s == 1 || s == 3) ? 1 : 0);
      chk($sformatf("step%0d_sel_b", s), sel_b0, (s >= 2) ? 1 : 0);
      chk($sformatf("step%0d_shift", s), shift0, (s == 0) ? 0 : ((s == 3) ? 2 : 1));
      chk($sformatf("step%0d_busy", s), busy0, 1);
      @(negedge clk);
    end
    chk("done_busy_low", busy0, 0);
    chk("done_sel_low", {sel_a0, sel_b0, shift0}, 0);
  endtask

  initial begin
`ifdef MULT8X8_SIGNED_EN
    vecs[0] = '{8'd5,   8'd7,   16'd35};
    vecs[1] = '{8'hFF,  8'hFF,  16'h0001};
    vecs[2] = '{8'hA5,  8'h3C,  16'hEAAC};
    vecs[3] = '{8'h00,  8'hFF,  16'h0000};
    vecs[4] = '{8'h80,  8'h7F,  16'hC080};
    vecs[5] = '{8'd100, 8'hFD,  16'hFED4};
    vecs[6] = '{8'hFF,  8'h01,  16'hFFFF};
    vecs[7] = '{8'h80,  8'h80,  16'h4000};
`else
    vecs[0] = '{8'd5,   8'd7,   16'd35};
    vecs[1] = '{8'hFF,  8'hFF,  16'hFE01};
    vecs[2] = '{8'hA5,  8'h3C,  16'h26AC};
    vecs[3] = '{8'h00,  8'hFF,  16'h0000};
    vecs[4] = '{8'h80,  8'h7F,  16'h3F80};
    vecs[5] = '{8'd100, 8'hFD,  16'h62D4};
    vecs[6] = '{8'hFF,  8'h01,  16'h00FF};
    vecs[7] = '{8'h80,  8'h80,  16'h4000};
`endif

    // The reset state is checked while reset is held.
    #2;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset_a = 1'b1;

    // Table-driven operations.
    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].exp);

    // start is held for 6 cycles and the operands change mid-run. Only the DONE-cycle start relaunches.
    @(negedge clk);
    start = 1'b1; dataa = 8'd15; datab = 8'd10;
    push_exp(16'd150);
    @(negedge clk);
    dataa = 8'd3; datab = 8'd3;
    chk("held_s0_busy", busy0, 1);
    repeat (3) @(negedge clk);
    chk("held_s3_sel", {sel_a0, sel_b0, shift0}, 4'b1110);
    @(negedge clk);
    push_exp(16'd9);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_s0_busy", busy0, 1);
    chk("b2b_done1_dropped", done1, 0);
    chk("b2b_acc_cleared", prod0, 0);
    repeat (4) @(negedge clk);

    // An asynchronous reset during S2 of a 200*100 run discards the operation.
    @(negedge clk);
    start = 1'b1; dataa = 8'd200; datab = 8'd100;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_s2", {sel_a0, sel_b0, shift0}, 4'b0101);
    reset_a = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clk);
    reset_a = 1'b1;
    do_op(8'd12, 8'd12, 16'd144);

    // Done-hold behaviour across 10 idle cycles, then the drop on the next accept.
    do_op(8'd7, 8'd9, 16'd63);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_done1_held", i), done1, 1);
      chk($sformatf("idle%0d_done0_pulse", i), done0, 0);
      chk($sformatf("idle%0d_prod_held", i), prod1, 63);
    end
    do_op(8'd3, 8'd5, 16'd15);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult8x8_seq_ctrl.md
Name: mult8x8_seq_ctrl

Overview:
- Sequencing and accumulation stage for the sequential 8x8 multiplier.
- Latches two 8-bit operands on start, then steps through the four nibble pairs over four cycles. Each step drives the select lines of the 4-bit nibble muxes, forms the 4x4 partial product, aligns it by 0/4/8 bits and accumulates it into a 16-bit product.
- Sits directly upstream of the nibble muxes (owns their select lines) and downstream of their outputs. The mux/4x4/shift path is instantiated internally so the block is self-contained.

Parameters:
- DONE_HOLD, 0, 0: done_flag is a 1-cycle pulse in DONE; 1: done_flag stays high in IDLE until the next accepted start.

Ports:
- clk  input  1  rising-edge clock
- reset_a  input  1  asynchronous active-low reset
- start  input  1  request; sampled on the rising edge when state is IDLE or DONE
- dataa  input  8  multiplicand, latched on accepted start
- datab  input  8  multiplier, latched on accepted start
- sel_a  output  1  nibble select for operand A mux (0 = [3:0], 1 = [7:4])
- sel_b  output  1  nibble select for operand B mux
- shift  output  2  alignment of the current partial product: 0 = none, 1 = <<4, 2 = <<8
- busy  output  1  high in states S0..S3
- done_flag  output  1  result valid indicator
- product8x8_out  output  16  accumulated product, registered

Behaviour:
- Reset (reset_a low, async):
  - state = IDLE; operand regs = 0, product8x8_out = 0, done_flag = 0.
  - Moore outputs in IDLE: sel_a = 0, sel_b = 0, shift = 0, busy = 0.
- States: IDLE, S0, S1, S2, S3, DONE (3-bit encoding).
- IDLE: when start = 1, latch dataa/datab, clear the accumulator to 0 and go to S0. Otherwise stay.
- Moore outputs per state, and the partial product added on the exit edge:
  - S0: sel_a = 0, sel_b = 0, shift = 0; adds a[3:0]*b[3:0].
  - S1: sel_a = 1, sel_b = 0, shift = 1; adds a[7:4]*b[3:0] << 4.
  - S2: sel_a = 0, sel_b = 1, shift = 1; adds a[3:0]*b[7:4] << 4.
  - S3: sel_a = 1, sel_b = 1, shift = 2; adds a[7:4]*b[7:4] << 8.
- Transitions: S0 -> S1 -> S2 -> S3 -> DONE, one step per edge, unconditional.
- Arithmetic: the 4x4 product is 8 bits, zero-extended to 16 before the shift. The accumulator is 16 bits and never overflows (max 65025).
- Latency: start sampled at edge E0; product final and done_flag = 1 after edge E4 (4 cycles).
- DONE: done_flag = 1, product held, busy = 0.
  - start = 1: accept as a new operation (back-to-back): latch, clear, go to S0; done_flag drops.
  - Else: go to IDLE.
    - DONE_HOLD = 0: done_flag = 0 in IDLE.
    - DONE_HOLD = 1: done_flag stays 1 in IDLE until the next accepted start.
- start while busy: ignored; operands are not relatched.
- dataa/datab changes after the accept edge have no effect on the result.
- product8x8_out:
  - Intermediate sums are visible during S0..S3.
  - Holds the result until the next accepted start, which clears it to 0 at the accept edge.
- reset_a asserted mid-operation: immediate return to the reset state. No partial result is retained.

Optional Feature:
- Macro: MULT8X8_SIGNED_EN.
- Defined:
  - Operands are two's complement. At the accept edge, store magnitudes plus sign = dataa[7] ^ datab[7].
  - The unsigned sequence runs unchanged. The transition S3 -> DONE writes the negated sum if sign = 1.
  - Latency is unchanged.
  - Magnitude of -128 is 128 (9-bit intermediate is acceptable).
- Undefined: unsigned only; no sign logic synthesised.

Test Plan:
- dataa = 5, datab = 7, 1-cycle start -> sel_a/sel_b/shift = 0/0/0, 1/0/1, 0/1/1, 1/1/2 on consecutive cycles; product8x8_out = 35 with done_flag = 1 exactly 4 cycles after the start edge.
- dataa = 255, datab = 255 -> 65025 (0xFE01). Also dataa = 0xA5, datab = 0x3C -> 9900 (0x26AC). Also dataa = 0, datab = 0xFF -> 0.
- start = 1 held for 6 cycles with dataa = 15, datab = 10, and operands changed to 3/3 mid-run -> first result 150. The DONE-cycle start launches a second op of 3*3 = 9; starts during S0..S3 are ignored.
- reset_a pulsed low in S2 of a 200*100 run -> all outputs zero immediately. A subsequent start with 12*12 -> 144, unaffected by the aborted run.
- DONE_HOLD = 1 -> done_flag stays high through 10 idle cycles after 7*9 = 63 and drops on the edge accepting the next start. DONE_HOLD = 0 -> single-cycle pulse.
- MULT8X8_SIGNED_EN defined -> (-1)*(-1) = 0x0001; (-128)*127 = 0xC080; 100*(-3) = 0xFED4; latency still 4 cycles.
